display_writer: RTL and testbench



---
 rtl/display_writer.sv | 152 +++++++++++++++
 tb/tb_display_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/display_writer.sv
// Byte-stream terminal writer into an 80x32 display RAM; writes land one cycle after acceptance.
// char_ready is low only while a screen or line clear runs. Optional macro: DISP_WR_BACKSPACE_EN.
module display_writer #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 32,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cur_x,
  output logic [4:0]        cur_y,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_CLR_SCR, S_CLR_LINE} state_t;

  localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [6:0]        X_LAST    = 7'(COLS - 1);
  localparam logic [4:0]        Y_LAST    = 5'(ROWS - 1);

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_x, w_x_nxt;
  logic [4:0]        r_y, w_y_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic              w_accept;
  logic              w_printable;
  logic              w_row_adv;
  logic [ADDR_W-1:0] w_cell;

  assign char_ready  = (r_state == S_IDLE);
  assign busy        = !char_ready;
  assign w_accept    = char_valid && char_ready;
  assign w_printable = (char_in >= 8'h20) && (char_in != 8'h7F);
  assign w_cell      = ADDR_W'(r_y) * ADDR_W'(COLS) + ADDR_W'(r_x);

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_idx_nxt     = r_idx;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_row_adv     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_cell;
            w_wr_data_nxt = char_in;
            if (r_x == X_LAST) begin
              w_x_nxt   = 7'd0;
              w_row_adv = 1'b1;
            end else begin
              w_x_nxt = r_x + 7'd1;
            end
          end else begin
            case (char_in)
              8'h0A: begin
                w_x_nxt   = 7'd0;
                w_row_adv = 1'b1;
              end
              8'h0D: w_x_nxt = 7'd0;
              8'h0C: begin
                w_state_nxt = S_CLR_SCR;
                w_idx_nxt   = '0;
                w_x_nxt     = 7'd0;
                w_y_nxt     = 5'd0;
              end
`ifdef DISP_WR_BACKSPACE_EN
              // Previous cell is always cell-1, including the wrap to the row above.
              8'h08: begin
                if (r_x != 7'd0 || r_y != 5'd0) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_cell - ADDR_W'(1);
                  w_wr_data_nxt = BLANK;
                  if (r_x != 7'd0) begin
                    w_x_nxt = r_x - 7'd1;
                  end else begin
                    w_x_nxt = X_LAST;
                    w_y_nxt = r_y - 5'd1;
                  end
                end
              end
`endif
              default: ;
            endcase
          end
          if (w_row_adv) begin
            if (r_y != Y_LAST) begin
              w_y_nxt = r_y + 5'd1;
            end else begin
              w_y_nxt     = 5'd0;
              w_state_nxt = S_CLR_LINE;
              w_idx_nxt   = '0;
            end
          end
        end
      end
      S_CLR_SCR, S_CLR_LINE: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_idx;
        w_wr_data_nxt = BLANK;
        if (r_idx == ((r_state == S_CLR_SCR) ? SCR_LAST : LINE_LAST)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_x       <= 7'd0;
      r_y       <= 5'd0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign cur_x   = r_x;
  assign cur_y   = r_y;

endmodule

// File: tb/tb_display_writer.sv
// Scoreboard bench for display_writer: a cursor/screen model predicts writes, a monitor checks them.
module tb_display_writer;

  localparam int C = 80;
  localparam int R = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  display_writer dut (
    .clk(clk), .resetn(resetn), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];
  bit mon_en = 1'b1;
  int mx = 0;
  int my = 0;
  int last_clr = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_w(input int a, input int d);
    exp_q.push_back(a * 256 + d);
  endtask

  task automatic adv_row();
    if (my < R - 1) my++;
    else begin
      my = 0;
      for (int a = 0; a < C; a++) push_w(a, 32);
      last_clr = C;
    end
  endtask

  // Terminal semantics: what a screen should receive for each byte.
  task automatic model(input logic [7:0] b);
    last_clr = 0;
    if (b >= 8'h20 && b != 8'h7F) begin
      push_w(my * C + mx, int'(b));
      if (mx == C - 1) begin mx = 0; adv_row(); end
      else mx++;
    end else if (b == 8'h0A) begin
      mx = 0; adv_row();
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0C) begin
      for (int a = 0; a < C * R; a++) push_w(a, 32);
      mx = 0; my = 0; last_clr = C * R;
    end
`ifdef DISP_WR_BACKSPACE_EN
    else if (b == 8'h08) begin
      if (mx > 0) begin mx--; push_w(my * C + mx, 32); end
      else if (my > 0) begin my--; mx = C - 1; push_w(my * C + mx, 32); end
    end
`endif
  endtask

  always @(negedge clk) begin
    if (resetn && mon_en && wr_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_wr: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        chk("wr_addr_data", {12'h0, wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte (and any clear) completes.
  task automatic send(input logic [7:0] b);
    int g = 0;
    int cnt = 0;
    char_in = b;
    char_valid = 1'b1;
    while (!char_ready && g < 6000) begin @(negedge clk); g++; end
    if (!char_ready) begin
      chk("accept_timeout", 0, 1);
      char_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    model(b);
    @(negedge clk);
    char_valid = 1'b0;
    chk("cur_x", cur_x, mx);
    chk("cur_y", cur_y, my);
    chk("ready_after_accept", char_ready, last_clr == 0);
    if (last_clr > 0) begin
      while (busy && cnt < 6000) begin cnt++; @(negedge clk); end
      chk("busy_len", cnt, last_clr);
    end
  endtask

  initial begin
    int prev;
    int g;
    int cnt;
    logic [7:0] b;
    int r;

    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", char_ready, 1);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cur", {cur_y, cur_x}, 0);
    chk("rst_busy", busy, 0);

    send(8'h41);
    for (int i = 0; i < C - 2; i++) send(8'h30 + 8'(i % 40));
    send(8'h5A);

    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h0D);
    prev = acc_cyc;
    send(8'h0A);
    chk("back_to_back", acc_cyc - prev, 1);

    send(8'h0C);
    for (int i = 0; i < R - 1; i++) send(8'h0A);
    for (int i = 0; i < C - 1; i++) send(8'h80 + 8'(i));
    send(8'h51);

    for (int i = 0; i < 4; i++) send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h7E);
    send(8'h08);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = $urandom_range(0, 1) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(128, 255));
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 88) b = 8'h08;
      else if (r < 89) b = 8'h0C;
      else begin r = $urandom_range(0, 32); b = (r == 32) ? 8'h7F : 8'(r); end
      send(b);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    mon_en = 1'b0;
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    g = 0;
    cnt = 0;
    while (g < 5000) begin
      if (wr_en) cnt++;
      if (cnt == 100) break;
      @(negedge clk);
      g++;
    end
    chk("abort_point_addr", wr_addr, 99);
    resetn = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_cur", {cur_y, cur_x}, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_ready", char_ready, 1);
    chk("abort_idle_wr", wr_en, 0);
    exp_q.delete();
    mx = 0;
    my = 0;
    mon_en = 1'b1;

    send(8'h42);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
